// File: rtl/regfile_pkg.sv
// Shared sizing constants and types for the 16 x 32 general-purpose register file.
package regfile_pkg;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;

  typedef logic [ADDR_W-1:0]           reg_addr_t;
  typedef logic [DATA_W-1:0]           reg_data_t;
  typedef reg_data_t [NUM_REGS-1:0]    reg_array_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: selects an entry from the array, or the forwarded
// write data when the top asserts fwd_en.
module regfile_read_port
  import regfile_pkg::*;
(
  input  reg_array_t regs,
  input  reg_addr_t  addr,
  input  logic       fwd_en,
  input  reg_data_t  fwd_data,
  output reg_data_t  data
);

  assign data = fwd_en ? fwd_data : regs[addr];

endmodule

// File: rtl/register_file.sv
// 16 x 32 register file: one synchronous write port, two combinational read ports,
// full array exported on regfile. Define RF_BYPASS_EN for write-through forwarding.
module register_file
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] regfile [NUM_REGS-1:0]
);

  reg_array_t mem;
  logic       fwd1;
  logic       fwd2;

  // NOTE: the whole array is cleared on reset on purpose -- software relies on
  // every register starting at zero, and there is no hardwired-zero entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (we3) begin
      mem[a3] <= wd3;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_export
    assign regfile[i] = mem[i];
  end

`ifdef RF_BYPASS_EN
  // Reset must still force zero reads, so forwarding is suppressed while rst is high.
  assign fwd1 = we3 && !rst && (a1 == a3);
  assign fwd2 = we3 && !rst && (a2 == a3);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  regfile_read_port u_rd1 (
    .regs     (mem),
    .addr     (a1),
    .fwd_en   (fwd1),
    .fwd_data (wd3),
    .data     (rd1)
  );

  regfile_read_port u_rd2 (
    .regs     (mem),
    .addr     (a2),
    .fwd_en   (fwd2),
    .fwd_data (wd3),
    .data     (rd2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file; expectations follow RF_BYPASS_EN.
module tb_register_file;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              we3 = 1'b0;
  logic [ADDR_W-1:0] a3  = '0;
  logic [DATA_W-1:0] wd3 = '0;
  logic [ADDR_W-1:0] a1  = '0;
  logic [ADDR_W-1:0] a2  = '0;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] regfile [NUM_REGS-1:0];

  int checks   = 0;
  int failures = 0;

  register_file dut (
    .clk     (clk),
    .rst     (rst),
    .we3     (we3),
    .a3      (a3),
    .wd3     (wd3),
    .a1      (a1),
    .a2      (a2),
    .rd1     (rd1),
    .rd2     (rd2),
    .regfile (regfile)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] exp_bypass;

  initial begin
    // Reset pulse entirely between edges (posedge at t=5)
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < NUM_REGS; i++) check($sformatf("reset_reg%0d", i), regfile[i], '0);
    check("reset_rd1", rd1, '0);
    check("reset_rd2", rd2, '0);
    #1 rst = 1'b0;

    // Masked write
    we3 = 1'b0; a3 = 4'd1; wd3 = 32'd2;
    tick();
    check("masked_write_reg1", regfile[1], '0);

    // Write / read
    we3 = 1'b1; a3 = 4'd9; wd3 = 32'd6;
    tick();
    we3 = 1'b0; a1 = 4'd9;
    #1 check("write9_rd1", rd1, 32'd6);
    check("write9_regfile", regfile[9], 32'd6);
    we3 = 1'b1; a3 = 4'd14; wd3 = 32'd9;
    tick();
    we3 = 1'b0; a2 = 4'd14;
    #1 check("write14_rd2", rd2, 32'd9);

    // Dual read same address, never-written address
    a1 = 4'd9; a2 = 4'd9;
    #1 check("dual_rd1", rd1, 32'd6);
    check("dual_rd2", rd2, 32'd6);
    a1 = 4'd4;
    #1 check("unwritten_rd1", rd1, '0);

    // Same-cycle read of the entry being written
    we3 = 1'b1; a3 = 4'd9; wd3 = 32'hDEADBEEF; a1 = 4'd9; a2 = 4'd14;
`ifdef RF_BYPASS_EN
    exp_bypass = 32'hDEADBEEF;
`else
    exp_bypass = 32'd6;
`endif
    #1 check("rw_same_cycle_rd1", rd1, exp_bypass);
    check("rw_same_cycle_rd2_other", rd2, 32'd9);
    check("rw_same_cycle_regfile", regfile[9], 32'd6);
    tick();
    we3 = 1'b0;
    #1 check("rw_after_edge_rd1", rd1, 32'hDEADBEEF);

    // Reset coincident with a write
    we3 = 1'b1; a3 = 4'd3; wd3 = 32'hA5;
    tick();
    check("pre_reset_reg3", regfile[3], 32'hA5);
    wd3 = 32'h5A; a1 = 4'd3; rst = 1'b1;
    #1 check("rst_async_reg3", regfile[3], '0);
    check("rst_rd1_zero", rd1, '0);
    tick();
    check("rst_write_dropped", regfile[3], '0);
    check("rst_cleared_reg9", regfile[9], '0);
    check("rst_cleared_reg14", regfile[14], '0);
    rst = 1'b0;
    tick();
    check("post_reset_write_reg3", regfile[3], 32'h5A);
    we3 = 1'b1; a3 = 4'd15; wd3 = 32'h1234_5678; a2 = 4'd15;
    tick();
    we3 = 1'b0;
    #1 check("post_reset_reg15_rd2", rd2, 32'h1234_5678);
    check("post_reset_reg0_untouched", regfile[0], '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
